// File: rtl/sbox_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// sbox_port_arbiter_pkg : shared widths and tag record for the S-box arbiter
// Rev 1.0
// ============================================================================
package sbox_port_arbiter_pkg;

  localparam int c_aw  = 10;
  localparam int c_dw  = 8;
  localparam int c_lat = 2;
  localparam int c_iw  = 3;  // wide enough to index up to 8 requesters

  typedef logic [c_iw-1:0] idx_t;

  typedef struct packed {
    logic valid;
    idx_t idx;
  } tag_t;

  function automatic idx_t wrap_inc(input idx_t i, input int n);
    return (int'(i) == n - 1) ? '0 : idx_t'(i + 1'b1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// rr_pick2 : combinational two-winner round-robin search from a pointer
// Rev 1.0
// ============================================================================
module rr_pick2
  import sbox_port_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] valid,
  input  idx_t            ptr,
  output logic            a_vld,
  output idx_t            a_idx,
  output logic            b_vld,
  output idx_t            b_idx
);

  // Two passes: indices at/after the pointer first, then the wrapped part.
  always_comb begin
    a_vld = 1'b0;
    a_idx = '0;
    b_vld = 1'b0;
    b_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (valid[i] && (i >= int'(ptr))) begin
        if (!a_vld) begin
          a_vld = 1'b1;
          a_idx = idx_t'(i);
        end else if (!b_vld) begin
          b_vld = 1'b1;
          b_idx = idx_t'(i);
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (valid[i] && (i < int'(ptr))) begin
        if (!a_vld) begin
          a_vld = 1'b1;
          a_idx = idx_t'(i);
        end else if (!b_vld) begin
          b_vld = 1'b1;
          b_idx = idx_t'(i);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sbox_port_arbiter.sv
`default_nettype none
// ============================================================================
// sbox_port_arbiter : shares one dual-port S-box BRAM among NREQ requesters
// Rev 1.0
// ============================================================================
module sbox_port_arbiter
  import sbox_port_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = c_lat,
  parameter int AW   = c_aw
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [NREQ*c_dw-1:0] rsp_data,
  output logic [AW-1:0]        bram_addra,
  output logic [AW-1:0]        bram_addrb,
  output logic                 bram_en,
  output logic                 bram_rst,
  input  logic [c_dw-1:0]      bram_doa,
  input  logic [c_dw-1:0]      bram_dob,
  output logic                 busy
);

  idx_t            r_ptr;
  logic            r_bram_rst;
  tag_t            r_tag_a [LAT];
  tag_t            r_tag_b [LAT];

  logic [NREQ-1:0] w_cand;
  logic            w_a_vld;
  idx_t            w_a_idx;
  logic            w_b_vld;
  idx_t            w_b_idx;
  logic [NREQ-1:0] w_a_sel;
  logic [NREQ-1:0] w_b_sel;
  tag_t            w_out_a;
  tag_t            w_out_b;

  // No grants until the BRAM output registers have been cleared once.
  assign w_cand = r_bram_rst ? '0 : req_valid;

  rr_pick2 #(
    .NREQ (NREQ)
  ) u_pick (
    .valid (w_cand),
    .ptr   (r_ptr),
    .a_vld (w_a_vld),
    .a_idx (w_a_idx),
    .b_vld (w_b_vld),
    .b_idx (w_b_idx)
  );

  assign w_out_a = r_tag_a[LAT-1];
  assign w_out_b = r_tag_b[LAT-1];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
      logic w_ra_hit;
      logic w_rb_hit;

      assign w_a_sel[gi]  = w_a_vld && (w_a_idx == idx_t'(gi));
      assign w_b_sel[gi]  = w_b_vld && (w_b_idx == idx_t'(gi));
      assign req_ready[gi] = w_a_sel[gi] | w_b_sel[gi];

      assign w_ra_hit = w_out_a.valid && (w_out_a.idx == idx_t'(gi));
      assign w_rb_hit = w_out_b.valid && (w_out_b.idx == idx_t'(gi));
      assign rsp_valid[gi] = w_ra_hit | w_rb_hit;
      assign rsp_data[gi*c_dw +: c_dw] = w_ra_hit ? bram_doa :
                                         (w_rb_hit ? bram_dob : '0);
    end
  endgenerate

  // Selects are one-hot or zero, so an AND-OR mux leaves idle ports at 0.
  always_comb begin
    bram_addra = '0;
    bram_addrb = '0;
    for (int i = 0; i < NREQ; i++) begin
      bram_addra = bram_addra | ({AW{w_a_sel[i]}} & req_addr[i*AW +: AW]);
      bram_addrb = bram_addrb | ({AW{w_b_sel[i]}} & req_addr[i*AW +: AW]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr      <= '0;
      r_bram_rst <= 1'b1;
      for (int s = 0; s < LAT; s++) begin
        r_tag_a[s] <= '0;
        r_tag_b[s] <= '0;
      end
    end else begin
      r_bram_rst <= 1'b0;
      if (w_a_vld) begin
        r_ptr <= wrap_inc(w_b_vld ? w_b_idx : w_a_idx, NREQ);
      end
      r_tag_a[0] <= {w_a_vld, w_a_idx};
      r_tag_b[0] <= {w_b_vld, w_b_idx};
      for (int s = 1; s < LAT; s++) begin
        r_tag_a[s] <= r_tag_a[s-1];
        r_tag_b[s] <= r_tag_b[s-1];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < LAT; s++) begin
      busy = busy | r_tag_a[s].valid | r_tag_b[s].valid;
    end
  end

  assign bram_en  = rst;
  assign bram_rst = r_bram_rst;

endmodule
`default_nettype wire

// File: tb/tb_sbox_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sbox_port_arbiter : directed and randomised checks with a BRAM S-box model
// Rev 1.0
// ============================================================================
module tb_sbox_port_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam int AW   = 10;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ*8-1:0]   rsp_data;
  logic [AW-1:0]       bram_addra;
  logic [AW-1:0]       bram_addrb;
  logic                bram_en;
  logic                bram_rst;
  logic [7:0]          bram_doa = 8'h00;
  logic [7:0]          bram_dob = 8'h00;
  logic                busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sbox_port_arbiter #(
    .NREQ (NREQ),
    .LAT  (LAT),
    .AW   (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .bram_addra (bram_addra),
    .bram_addrb (bram_addrb),
    .bram_en    (bram_en),
    .bram_rst   (bram_rst),
    .bram_doa   (bram_doa),
    .bram_dob   (bram_dob),
    .busy       (busy)
  );

  // Two-stage BRAM: address register, then output register.
  logic [7:0]    mem [1024];
  logic [AW-1:0] qa = '0;
  logic [AW-1:0] qb = '0;

  always @(posedge clk) begin
    if (bram_en) begin
      qa <= bram_addra;
      qb <= bram_addrb;
      if (bram_rst) begin
        bram_doa <= 8'h00;
        bram_dob <= 8'h00;
      end else begin
        bram_doa <= mem[qa];
        bram_dob <= mem[qb];
      end
    end
  end

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h01;
    for (int k = 0; k < 254; k++) v = gmul(v, x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [7:0]         sb [256];
  logic [NREQ-1:0]    mv;
  logic [NREQ*AW-1:0] maddr;
  logic [NREQ-1:0]    erdy, ev0, ev1;
  logic [NREQ*8-1:0]  ed0, ed1;
  logic [AW-1:0]      ea, eb;
  int                 mptr, ga, gb, nsel;
  int                 wcnt [NREQ];

  initial begin
    for (int i = 0; i < 256; i++) sb[i] = sbox(8'(i));
    for (int a = 0; a < 1024; a++) mem[a] = sb[a % 256] ^ {4{2'(a / 256)}};

    rst = 1'b0;
    req_valid = 4'b1111;
    req_addr = {10'h003, 10'h002, 10'h001, 10'h000};
    step();
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_rsp_valid", rsp_valid, 4'b0000);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_bram_en", bram_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bram_rst", bram_rst, 1'b1);

    // Release with all four requesting
    step();
    rst = 1'b1;
    #1;
    chk("c0_bram_rst", bram_rst, 1'b1);
    chk("c0_ready", req_ready, 4'b0000);
    chk("c0_bram_en", bram_en, 1'b1);
    step();
    chk("c1_bram_rst", bram_rst, 1'b0);
    chk("c1_ready", req_ready, 4'b0011);
    chk("c1_addra", bram_addra, 10'h000);
    chk("c1_addrb", bram_addrb, 10'h001);
    chk("c1_busy", busy, 1'b0);
    step();
    chk("c2_ready", req_ready, 4'b1100);
    chk("c2_addra", bram_addra, 10'h002);
    chk("c2_addrb", bram_addrb, 10'h003);
    chk("c2_busy", busy, 1'b1);
    step();
    chk("c3_ready", req_ready, 4'b0011);
    chk("c3_rsp_valid", rsp_valid, 4'b0011);
    chk("c3_rsp_data", rsp_data, 32'h0000_7C63);
    req_valid = 4'b0000;
    #1;
    chk("c3_ready_drop", req_ready, 4'b0000);
    step();
    chk("c4_rsp_valid", rsp_valid, 4'b1100);
    chk("c4_rsp_data", rsp_data, 32'h7B77_0000);
    step();
    chk("c5_rsp_valid", rsp_valid, 4'b0000);
    chk("c5_rsp_data", rsp_data, 32'h0);
    chk("c5_busy", busy, 1'b0);

    // Requester 2 alone, two back-to-back lookups
    req_valid = 4'b0100;
    req_addr = {10'h003, 10'h000, 10'h001, 10'h000};
    #1;
    chk("solo1_ready", req_ready, 4'b0100);
    chk("solo1_addra", bram_addra, 10'h000);
    chk("solo1_addrb", bram_addrb, 10'h000);
    step();
    req_addr = {10'h003, 10'h001, 10'h001, 10'h000};
    #1;
    chk("solo2_ready", req_ready, 4'b0100);
    chk("solo2_addra", bram_addra, 10'h001);
    chk("solo2_addrb", bram_addrb, 10'h000);
    step();
    req_valid = 4'b0000;
    chk("solo_rsp1_valid", rsp_valid, 4'b0100);
    chk("solo_rsp1_data", rsp_data, 32'h0063_0000);
    step();
    chk("solo_rsp2_valid", rsp_valid, 4'b0100);
    chk("solo_rsp2_data", rsp_data, 32'h007C_0000);
    step();
    chk("solo_idle", rsp_valid, 4'b0000);

    // Pointer is 3: wrap-around grant of 3 on A and 0 on B
    req_valid = 4'b1001;
    req_addr = {10'h010, 10'h000, 10'h000, 10'h011};
    #1;
    chk("wrap_ready", req_ready, 4'b1001);
    chk("wrap_addra", bram_addra, 10'h010);
    chk("wrap_addrb", bram_addrb, 10'h011);
    step();
    req_valid = 4'b1111;
    #1;
    chk("wrap_next_ptr", req_ready, 4'b0110);
    req_valid = 4'b0000;
    step();
    chk("wrap_rsp_valid", rsp_valid, 4'b1001);
    chk("wrap_rsp_data", rsp_data, 32'hCA00_0082);
    step();

    // Reset pulse with two lookups in flight
    req_valid = 4'b0011;
    req_addr = {10'h000, 10'h000, 10'h005, 10'h006};
    #1;
    chk("flight_ready", req_ready, 4'b0011);
    step();
    req_valid = 4'b0000;
    chk("flight_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("pulse_busy", busy, 1'b0);
    chk("pulse_rsp_valid", rsp_valid, 4'b0000);
    chk("pulse_bram_rst", bram_rst, 1'b1);
    step();
    rst = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("pulse_c0_ready", req_ready, 4'b0000);
    chk("pulse_c0_rsp", rsp_valid, 4'b0000);
    step();
    chk("pulse_c1_ready", req_ready, 4'b0011);
    chk("pulse_c1_rsp", rsp_valid, 4'b0000);
    req_valid = 4'b0000;
    step();
    chk("pulse_c2_rsp", rsp_valid, 4'b0000);
    chk("pulse_c2_busy", busy, 1'b0);
    step();
    chk("pulse_c3_rsp", rsp_valid, 4'b0000);

    // Random traffic against a reference arbiter and table model
    mptr = 0;
    mv = '0;
    maddr = '0;
    ev0 = '0; ev1 = '0; ed0 = '0; ed1 = '0;
    for (int i = 0; i < NREQ; i++) wcnt[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!mv[i] && ($urandom_range(0, 1) == 1)) begin
          mv[i] = 1'b1;
          maddr[i*AW +: AW] = AW'($urandom_range(0, 1023));
        end
      end
      req_valid = mv;
      req_addr = maddr;
      #1;
      ga = -1; gb = -1; nsel = 0;
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (mptr + k) % NREQ;
        if (mv[j]) begin
          if (nsel == 0) ga = j;
          else if (nsel == 1) gb = j;
          nsel++;
        end
      end
      erdy = '0;
      ea = '0;
      eb = '0;
      if (ga >= 0) begin erdy[ga] = 1'b1; ea = maddr[ga*AW +: AW]; end
      if (gb >= 0) begin erdy[gb] = 1'b1; eb = maddr[gb*AW +: AW]; end
      chk("rnd_ready", req_ready, erdy);
      chk("rnd_addra", bram_addra, ea);
      chk("rnd_addrb", bram_addrb, eb);
      chk("rnd_rsp_valid", rsp_valid, ev1);
      chk("rnd_rsp_data", rsp_data, ed1);
      ev1 = ev0;
      ed1 = ed0;
      ev0 = erdy;
      ed0 = '0;
      if (ga >= 0) ed0[ga*8 +: 8] = mem[ea];
      if (gb >= 0) ed0[gb*8 +: 8] = mem[eb];
      for (int i = 0; i < NREQ; i++) begin
        if (erdy[i]) begin
          chk("rnd_wait_bound", (wcnt[i] <= (NREQ + 1) / 2), 1'b1);
          wcnt[i] = 0;
          mv[i] = 1'b0;
        end else if (mv[i] && (ga >= 0)) begin
          wcnt[i]++;
        end
      end
      if (ga >= 0) mptr = (((gb >= 0) ? gb : ga) + 1) % NREQ;
      step();
    end
    req_valid = '0;
    #1;
    chk("drain1_rsp_valid", rsp_valid, ev1);
    chk("drain1_rsp_data", rsp_data, ed1);
    step();
    chk("drain2_rsp_valid", rsp_valid, ev0);
    chk("drain2_rsp_data", rsp_data, ed0);
    step();
    chk("drain_busy", busy, 1'b0);
    chk("drain_rsp_valid", rsp_valid, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
